// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and constants for the UART transmitter
// Optional parity state is present only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int          UART_DATA_BITS = 8;
    localparam logic [31:0] UART_TX_ADDR   = 32'h1001_0030;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - per-bit boundary tick generator for the UART transmitter
module uart_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_count;

    assign o_tick = i_enable && (r_count == LAST);

    // Counter wraps to 0 on every bit boundary and holds while disabled.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= o_tick ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter (even parity with UART_TX_PARITY_EN)
module uart_tx_periph
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  overrun
);

    tx_state_t                   r_state;
    logic [UART_DATA_BITS-1:0]   r_shift;
    logic [2:0]                  r_bit_cnt;
    logic                        r_tx;
    logic                        r_busy;
    logic                        r_tx_done;
    logic                        r_overrun;
`ifdef UART_TX_PARITY_EN
    logic                        r_parity;
`endif

    logic w_accept;
    logic w_drop;
    logic w_tick;
    logic w_unused_hi;

    assign w_accept    = wr_en && (r_state == ST_IDLE);
    assign w_drop      = wr_en && (r_state != ST_IDLE);
    assign w_unused_hi = ^wr_data[DATA_WIDTH-1:UART_DATA_BITS];

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_accept),
        .i_enable (r_state != ST_IDLE),
        .o_tick   (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_tx_done <= 1'b0;
            r_overrun <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_tx_done <= 1'b0;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (w_accept) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift   <= wr_data[UART_DATA_BITS-1:0];
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
`ifdef UART_TX_PARITY_EN
                        r_parity  <= ^wr_data[UART_DATA_BITS-1:0];
`endif
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (w_tick) begin
                        r_busy    <= 1'b0;
                        r_tx_done <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx      = r_tx;
    assign busy    = r_busy;
    assign tx_done = r_tx_done;
    assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - directed self-checking bench for uart_tx_periph at CLKS_PER_BIT=4
module tb_uart_tx_periph;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_periph #(
        .CLKS_PER_BIT (CPB),
        .DATA_WIDTH   (32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic start_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = {24'hABCDEF, d};
        tick();
        wr_en   = 1'b0;
    endtask

    // Entered in the first tx-low cycle; returns in the tx_done cycle.
    // A dropped 0xFF write is driven during frame cycle index inj (-1 for none).
    task automatic check_frame(input logic [7:0] d, input int inj, input logic ovr0);
        for (int i = 0; i < NBITS * CPB; i++) begin
            check($sformatf("f%02h c%0d tx", d, i), {31'b0, tx}, {31'b0, exp_bit(d, i / CPB)});
            check($sformatf("f%02h c%0d busy", d, i), {31'b0, busy}, 32'd1);
            check($sformatf("f%02h c%0d done", d, i), {31'b0, tx_done}, 32'd0);
            check($sformatf("f%02h c%0d ovr", d, i), {31'b0, overrun},
                  {31'b0, (inj >= 0 && i > inj) ? 1'b1 : ovr0});
            if (i == inj) begin
                wr_en   = 1'b1;
                wr_data = 32'h0000_00FF;
            end else begin
                wr_en   = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        check($sformatf("f%02h done pulse", d), {31'b0, tx_done}, 32'd1);
        check($sformatf("f%02h done busy", d), {31'b0, busy}, 32'd0);
        check($sformatf("f%02h done tx", d), {31'b0, tx}, 32'd1);
    endtask

    initial begin
        tick();
        tick();
        check("reset tx", {31'b0, tx}, 32'd1);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, tx_done}, 32'd0);
        check("reset ovr", {31'b0, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // 0x55 from idle
        start_write(8'h55);
        check_frame(8'h55, -1, 1'b0);
        tick();
        check("post 55 done cleared", {31'b0, tx_done}, 32'd0);
        tick();

        // 0xA3 with 0xFF written 10 cycles into the frame
        start_write(8'hA3);
        check_frame(8'hA3, 9, 1'b0);
        check("a3 ovr sticky", {31'b0, overrun}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("ff never sent c%0d", i), {31'b0, tx}, 32'd1);
            check($sformatf("ff idle busy c%0d", i), {31'b0, busy}, 32'd0);
            check($sformatf("ovr held c%0d", i), {31'b0, overrun}, 32'd1);
        end

        // 0x01 then 0x80 written in the tx_done cycle
        start_write(8'h01);
        check_frame(8'h01, -1, 1'b0);
        start_write(8'h80);
        check_frame(8'h80, -1, 1'b0);
        check("b2b ovr", {31'b0, overrun}, 32'd0);
        tick();

        // 0x0F abandoned by reset at cycle 15, after a dropped write
        start_write(8'h0F);
        for (int i = 0; i < 4; i++) tick();
        wr_en   = 1'b1;
        wr_data = 32'h0000_0033;
        tick();
        wr_en   = 1'b0;
        check("0f ovr set", {31'b0, overrun}, 32'd1);
        for (int i = 0; i < 9; i++) tick();
        check("0f c15 tx", {31'b0, tx}, 32'd1);
        check("0f c15 busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst tx", {31'b0, tx}, 32'd1);
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst done", {31'b0, tx_done}, 32'd0);
        check("midrst ovr", {31'b0, overrun}, 32'd0);
        begin
            logic seen_done;
            logic seen_low;
            seen_done = 1'b0;
            seen_low  = 1'b0;
            for (int i = 0; i < 60; i++) begin
                tick();
                if (tx_done) seen_done = 1'b1;
                if (!tx) seen_low = 1'b1;
            end
            check("midrst no done", {31'b0, seen_done}, 32'd0);
            check("midrst line idle", {31'b0, seen_low}, 32'd0);
        end

        // Frame after reset still works
        start_write(8'hC6);
        check_frame(8'hC6, -1, 1'b0);
        tick();

`ifdef UART_TX_PARITY_EN
        start_write(8'h07);
        check_frame(8'h07, -1, 1'b0);
        tick();
        start_write(8'h03);
        check_frame(8'h03, -1, 1'b0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (50 MHz / 115200 baud); legal values are 2 and above.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the bus data width; only bits [7:0] are transmitted.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit, synchronous active-high reset.
REQ-005 Port wr_en: input, 1 bit, write strobe for the TX register at 0x10010030, driven by bit 2 of the memory-map write-enable vector.
REQ-006 Port wr_data: input, DATA_WIDTH bits, store data from the core; [7:0] is the byte to send.
REQ-007 Port tx: output, 1 bit, serial line; idles high.
REQ-008 Port busy: output, 1 bit, high whenever a frame is in progress.
REQ-009 Port tx_done: output, 1 bit, one-cycle pulse at frame completion.
REQ-010 Port overrun: output, 1 bit, sticky flag set when a write is dropped.

Function
REQ-011 The block SHALL implement the states IDLE, START, DATA, PARITY (only when parity is compiled in; see REQ-025) and STOP.
REQ-012 In IDLE, wr_en=1 SHALL latch wr_data[7:0] into a shift register, clear the bit counter and baud counter, and move to START at the same edge; tx goes low in the following cycle.
REQ-013 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then move to DATA.
REQ-014 DATA SHALL send 8 bits LSB first, each for exactly CLKS_PER_BIT cycles; after bit 7 it SHALL move to PARITY, or to STOP when parity is absent.
REQ-015 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-016 tx_done SHALL be 1 in exactly the first IDLE cycle after STOP and 0 otherwise.
REQ-017 busy SHALL be registered and equal to (state != IDLE); it is 0 in the tx_done cycle.
REQ-018 The baud counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 on each bit boundary; the bit counter SHALL be 3 bits wide.
REQ-019 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity), measured from the first tx-low cycle to the tx_done cycle.
REQ-020 A write while busy=1 SHALL be ignored: the frame continues unchanged and overrun is set to 1.
REQ-021 overrun SHALL clear on the next accepted write; if a dropped write and an accepted write occur in the same cycle, set wins (this case cannot arise, because accept and drop are mutually exclusive).
REQ-022 A write in the tx_done cycle SHALL be accepted, giving back-to-back frames with no idle gap beyond that single cycle.
REQ-023 wr_data[DATA_WIDTH-1:8] SHALL be ignored.

Reset
REQ-024 rst=1 SHALL force, at the next edge and regardless of state (including mid-frame), the following: state=IDLE, tx=1, busy=0, tx_done=0, overrun=0, all counters 0, shift register 0; the partial frame is abandoned.

Configuration
REQ-025 Macro UART_TX_PARITY_EN, when defined, SHALL add state PARITY, which drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP.
REQ-026 Without UART_TX_PARITY_EN, no parity logic or state SHALL exist, and DATA SHALL go directly to STOP.

Structure
REQ-027 Package uart_pkg SHALL hold the state encoding type, UART_DATA_BITS=8, and the address constant UART_TX_ADDR=32'h10010030.
REQ-028 One sub-module, uart_baud_counter, SHALL generate the per-bit boundary tick from CLKS_PER_BIT, with synchronous clear on frame start and on rst.

Verification (CLKS_PER_BIT=4)
REQ-029 Write 0x55 from idle -> tx holds 0,1,0,1,0,1,0,1,0,1 for 4 cycles each; busy=1 for 40 cycles; tx_done pulses in cycle 41.
REQ-030 Write 0xA3, then write 0xFF 10 cycles later -> 0xA3 is sent intact; overrun=1 until the next accepted write; 0xFF is never sent.
REQ-031 Write 0x01, then write 0x80 in the tx_done cycle -> second start bit begins the next cycle; no dropped byte; overrun stays 0.
REQ-032 Write 0x0F, then assert rst for 1 cycle at cycle 15 -> the next cycle shows tx=1, busy=0; no tx_done pulse follows.
REQ-033 With UART_TX_PARITY_EN defined, write 0x07 -> parity bit is 1 and the frame is 44 cycles; write 0x03 -> parity bit is 0.
